// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU/LSU result inputs, load issue, register-file write port, scoreboard.
// WB_FWD_EN adds the register-read forwarding signals.
interface wb_arbiter_if;
    logic        i_alu_valid;
    logic [4:0]  i_alu_rd;
    logic [63:0] i_alu_wdata;
    logic        i_lsu_valid;
    logic        o_lsu_ready;
    logic [4:0]  i_lsu_rd;
    logic [63:0] i_lsu_wdata;
    logic        i_issue_valid;
    logic [4:0]  i_issue_rd;
    logic        o_wen;
    logic [4:0]  o_addr;
    logic [63:0] o_wdata;
    logic        o_alu_stall;
    logic [31:0] o_busy;
`ifdef WB_FWD_EN
    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic        o_rs1_fwd;
    logic        o_rs2_fwd;
    logic [63:0] o_rs1_fdata;
    logic [63:0] o_rs2_fdata;
`endif

    // Arbiter side.
    modport slave (
`ifdef WB_FWD_EN
        input  i_rs1_addr, i_rs2_addr,
        output o_rs1_fwd, o_rs2_fwd, o_rs1_fdata, o_rs2_fdata,
`endif
        input  i_alu_valid, i_alu_rd, i_alu_wdata,
        input  i_lsu_valid, i_lsu_rd, i_lsu_wdata,
        input  i_issue_valid, i_issue_rd,
        output o_lsu_ready, o_wen, o_addr, o_wdata, o_alu_stall, o_busy
    );

    // Pipeline side driving the results and consuming the write port.
    modport master (
`ifdef WB_FWD_EN
        output i_rs1_addr, i_rs2_addr,
        input  o_rs1_fwd, o_rs2_fwd, o_rs1_fdata, o_rs2_fdata,
`endif
        output i_alu_valid, i_alu_rd, i_alu_wdata,
        output i_lsu_valid, i_lsu_rd, i_lsu_wdata,
        output i_issue_valid, i_issue_rd,
        input  o_lsu_ready, o_wen, o_addr, o_wdata, o_alu_stall, o_busy
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU-priority merge of ALU and buffered LSU results onto one register-file
// write port, with starvation stall and load scoreboard. Optional feature macro: WB_FWD_EN.
module wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.slave   bus
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] wdata;
    } lsu_entry_t;

    lsu_entry_t    fifo_mem [2];
    logic [1:0]    count;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [CW-1:0] starve_cnt;
    logic          alu_stall;
    logic          wen;
    logic          wen_lsu;
    logic [4:0]    addr;
    logic [63:0]   wdata;
    logic [31:0]   busy;

    logic          lsu_ready;
    logic          push;
    logic          pop;
    logic          alu_win;
    lsu_entry_t    head;
    logic [4:0]    win_rd;
    logic [63:0]   win_data;
    logic          wen_next;
    logic          buf_full;
    logic [CW-1:0] starve_inc;
    logic          starve_hit;
    logic [31:0]   busy_next;

    assign lsu_ready  = (count != 2'd2);
    assign buf_full   = (count == 2'd2);
    assign push       = bus.i_lsu_valid & lsu_ready;
    assign alu_win    = bus.i_alu_valid & ~alu_stall;
    assign pop        = ~alu_win & (count != 2'd0);
    assign head       = fifo_mem[rd_ptr];
    assign win_rd     = alu_win ? bus.i_alu_rd    : head.rd;
    assign win_data   = alu_win ? bus.i_alu_wdata : head.wdata;
    // x0 winners are consumed without a register-file write.
    assign wen_next   = (alu_win | pop) & (win_rd != 5'd0);
    assign starve_inc = starve_cnt + CW'(1);
    assign starve_hit = buf_full & alu_win & (starve_inc == LIMIT);

    // NOTE: every variable gets a default first so the block stays combinational (no latch).
    always_comb begin
        busy_next = busy;
        if (wen && wen_lsu)
            busy_next[addr] = 1'b0;
        // A same-cycle issue to the register being cleared keeps it busy.
        if (bus.i_issue_valid && (bus.i_issue_rd != 5'd0))
            busy_next[bus.i_issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            starve_cnt <= '0;
            alu_stall  <= 1'b0;
            wen        <= 1'b0;
            wen_lsu    <= 1'b0;
            addr       <= 5'd0;
            wdata      <= 64'd0;
            busy       <= 32'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            if (buf_full && alu_win)
                starve_cnt <= starve_hit ? '0 : starve_inc;
            else
                starve_cnt <= '0;
            alu_stall <= starve_hit;

            wen     <= wen_next;
            wen_lsu <= pop;
            if (wen_next) begin
                addr  <= win_rd;
                wdata <= win_data;
            end
            busy <= busy_next;
        end
    end

    // NOTE: buffer storage is not reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{rd: bus.i_lsu_rd, wdata: bus.i_lsu_wdata};
    end

    assign bus.o_lsu_ready = lsu_ready;
    assign bus.o_wen       = wen;
    assign bus.o_addr      = addr;
    assign bus.o_wdata     = wdata;
    assign bus.o_alu_stall = alu_stall;
    assign bus.o_busy      = busy;

`ifdef WB_FWD_EN
    // Same-cycle write-to-read bypass the register file lacks.
    assign bus.o_rs1_fwd   = wen & (addr == bus.i_rs1_addr) & (bus.i_rs1_addr != 5'd0);
    assign bus.o_rs2_fwd   = wen & (addr == bus.i_rs2_addr) & (bus.i_rs2_addr != 5'd0);
    assign bus.o_rs1_fdata = wdata;
    assign bus.o_rs2_fdata = wdata;
`endif

endmodule
